cursor_layer: RTL and testbench

Parametrised, pipelined cursor overlay layer for the VGA compositor. It draws a SPR_W x SPR_H sprite, fetched row by row from an external synchronous ROM, at a cursor position that is latched once per frame and clamped to the visible area. Each pixel is coloured by mode: normal, hover (over a button region) or pressed (a flash lasting a set number of frames after a click). It drives the layer-3 request flag and RGB into the layer mixer with a fixed 2-cycle latency.

---
 rtl/cursor_layer.sv | 196 +++++++++++++++++++
 tb/tb_cursor_layer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_layer.sv
// -----------------------------------------------------------------------------
// cursor_layer
//
// Pipelined cursor overlay for the VGA compositor (layer 3). Draws a
// SPR_W x SPR_H sprite, fetched one row at a time from an external
// synchronous ROM, at a cursor position latched once per frame and clamped
// to the visible area. Opaque pixels are coloured by mode:
//   pressed (flash for PRESS_FRAMES frames after a click) -> 8'h80
//   hover   (pixel over a button region)                  -> 8'h00
//   normal                                                -> 8'hFF
// Output latency is fixed at 2 clocks. One pixel per clock, no stalls.
//
// Ports
//   clk          in   pixel clock
//   reset        in   asynchronous, active-high reset
//   frame_start  in   one-cycle pulse at start of vertical blanking
//   ArrowPosX/Y  in   requested cursor position (10 bit)
//   x_pos/y_pos  in   current scan position (10 bit)
//   en_hover     in   current pixel is inside a button region
//   click        in   one-cycle mouse-press pulse
//   rom_addr     out  sprite row address (combinational from y_pos, py)
//   rom_data     in   sprite row, one cycle after rom_addr; MSB = leftmost,
//                     a 0 bit is an opaque pixel
//   RqFlag3      out  layer requests this pixel
//   Red3/Green3/Blue3 out  8-bit colour
// -----------------------------------------------------------------------------
module cursor_layer #(
    parameter int SPR_AW       = 4,
    parameter int SPR_W        = 16,
    parameter int X_LIM        = 784,
    parameter int Y_LIM        = 584,
    parameter int PRESS_FRAMES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [9:0]        ArrowPosX,
    input  logic [9:0]        ArrowPosY,
    input  logic [9:0]        x_pos,
    input  logic [9:0]        y_pos,
    input  logic              en_hover,
    input  logic              click,
    output logic [SPR_AW-1:0] rom_addr,
    input  logic [SPR_W-1:0]  rom_data,
    output logic              RqFlag3,
    output logic [7:0]        Red3,
    output logic [7:0]        Green3,
    output logic [7:0]        Blue3
);

    localparam int SPR_H = 2 ** SPR_AW;
    localparam int CW    = $clog2(SPR_W);

    localparam logic [9:0] PX_RST = 10'd384;
    localparam logic [9:0] PY_RST = 10'd284;

    localparam logic [7:0] COL_PRESS  = 8'h80;
    localparam logic [7:0] COL_HOVER  = 8'h00;
    localparam logic [7:0] COL_NORMAL = 8'hFF;

    // Position shadow and press counter
    logic [9:0]    px_q, px_d;
    logic [9:0]    py_q, py_d;
    logic [7:0]    press_cnt_q, press_cnt_d;

    // Stage 0 combinational
    logic [9:0]    px_clamp_s, py_clamp_s;
    logic [10:0]   x_ext_s, y_ext_s, px_ext_s, py_ext_s;
    logic [10:0]   px_end_s, py_end_s;
    logic          hit_s;
    logic [CW-1:0] col_s;

    // Stage 1 registers / combinational
    logic          hit_q;
    logic [CW-1:0] col_q;
    logic          hov_q;
    logic [CW-1:0] bit_idx_s;
    logic          opaque_s;

    // Stage 2 (output) registers
    logic          rq_q, rq_d;
    logic [7:0]    pix_q, pix_d;

    // ---------------------------------------------------------------------
    // Stage 0: clamp, window test and ROM address
    // ---------------------------------------------------------------------
    assign px_clamp_s = (ArrowPosX > 10'(X_LIM)) ? 10'(X_LIM) : ArrowPosX;
    assign py_clamp_s = (ArrowPosY > 10'(Y_LIM)) ? 10'(Y_LIM) : ArrowPosY;

    // 11-bit compares so px+SPR_W cannot wrap past 1023 back into range.
    assign x_ext_s  = {1'b0, x_pos};
    assign y_ext_s  = {1'b0, y_pos};
    assign px_ext_s = {1'b0, px_q};
    assign py_ext_s = {1'b0, py_q};
    assign px_end_s = px_ext_s + 11'(SPR_W);
    assign py_end_s = py_ext_s + 11'(SPR_H);

    assign hit_s = (x_ext_s >= px_ext_s) && (x_ext_s < px_end_s) &&
                   (y_ext_s >= py_ext_s) && (y_ext_s < py_end_s);

    // Only the low bits of dx/dy are consumed; the low bits of a difference
    // depend only on the low bits of its operands.
    assign col_s    = x_pos[CW-1:0] - px_q[CW-1:0];
    assign rom_addr = y_pos[SPR_AW-1:0] - py_q[SPR_AW-1:0];

    // ---------------------------------------------------------------------
    // Stage 1: pick the pixel bit out of the returned ROM row.
    // SPR_W is a power of two, so SPR_W-1-col equals ~col.
    // ---------------------------------------------------------------------
    assign bit_idx_s = ~col_q;
    assign opaque_s  = hit_q && ~rom_data[bit_idx_s];

    // Next-state for cursor shadow and press flash counter
    always_comb begin
        px_d        = px_q;
        py_d        = py_q;
        press_cnt_d = press_cnt_q;
        if (frame_start) begin
            px_d = px_clamp_s;
            py_d = py_clamp_s;
        end else begin
            px_d = px_q;
            py_d = py_q;
        end
        // A click in the same cycle as frame_start reloads rather than counts.
        if (click) begin
            press_cnt_d = 8'(PRESS_FRAMES);
        end else if (frame_start && (press_cnt_q != 8'd0)) begin
            press_cnt_d = press_cnt_q - 8'd1;
        end else begin
            press_cnt_d = press_cnt_q;
        end
    end

    // Next-state for the output stage: colour by press / hover / normal
    always_comb begin
        rq_d  = 1'b0;
        pix_d = 8'h00;
        if (opaque_s) begin
            rq_d = 1'b1;
            if (press_cnt_q != 8'd0) begin
                pix_d = COL_PRESS;
            end else if (hov_q) begin
                pix_d = COL_HOVER;
            end else begin
                pix_d = COL_NORMAL;
            end
        end else begin
            rq_d  = 1'b0;
            pix_d = 8'h00;
        end
    end

    // Cursor shadow and press counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_q        <= PX_RST;
            py_q        <= PY_RST;
            press_cnt_q <= 8'd0;
        end else begin
            px_q        <= px_d;
            py_q        <= py_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    // Stage 1 pipeline registers (aligned with the ROM's registered output)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q <= 1'b0;
            col_q <= '0;
            hov_q <= 1'b0;
        end else begin
            hit_q <= hit_s;
            col_q <= col_s;
            hov_q <= en_hover;
        end
    end

    // Stage 2 output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rq_q  <= 1'b0;
            pix_q <= 8'h00;
        end else begin
            rq_q  <= rq_d;
            pix_q <= pix_d;
        end
    end

    assign RqFlag3 = rq_q;
    assign Red3    = pix_q;
    assign Green3  = pix_q;
    assign Blue3   = pix_q;

endmodule

// File: tb/tb_cursor_layer.sv
// -----------------------------------------------------------------------------
// tb_cursor_layer
//
// Self-checking bench for cursor_layer. Pixels are driven on the falling
// edge; for each one the bench's own sprite model pushes the expected
// {RqFlag3, R, G, B} with the clock count at which it must appear. A
// monitor pops and compares entries 1 time unit after the rising edge.
// Click / frame_start pulses are only issued together with off-sprite idle
// pixels so the colour of in-flight opaque pixels is never ambiguous.
// -----------------------------------------------------------------------------
module tb_cursor_layer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [9:0]  ArrowPosX, ArrowPosY;
    logic [9:0]  x_pos, y_pos;
    logic        en_hover;
    logic        click;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        RqFlag3;
    logic [7:0]  Red3, Green3, Blue3;

    cursor_layer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .ArrowPosX   (ArrowPosX),
        .ArrowPosY   (ArrowPosY),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .en_hover    (en_hover),
        .click       (click),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .RqFlag3     (RqFlag3),
        .Red3        (Red3),
        .Green3      (Green3),
        .Blue3       (Blue3)
    );

    always #5 clk = ~clk;

    // Synchronous sprite ROM: row r is opaque only at column r (diagonal).
    logic [15:0] rom_mem [16];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    typedef struct {
        int          due;
        logic [24:0] exp;
        int          x;
        int          y;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Bench model state
    int m_px    = 384;
    int m_py    = 284;
    int m_press = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if ({RqFlag3, Red3, Green3, Blue3} !== e.exp) begin
                errors++;
                $display("FAIL pixel x=%0d y=%0d got rq=%b rgb=%h/%h/%h expected rq=%b rgb=%h",
                         e.x, e.y, RqFlag3, Red3, Green3, Blue3, e.exp[24], e.exp[23:0]);
            end
        end
    end

    task automatic drive(input int x, input int y, input logic hov,
                         input logic fs, input logic clk_p);
        exp_t        e;
        int          row, col;
        logic        op;
        logic [7:0]  v;
        @(negedge clk);
        x_pos       = 10'(x);
        y_pos       = 10'(y);
        en_hover    = hov;
        frame_start = fs;
        click       = clk_p;
        op = 1'b0;
        if (x >= m_px && x < m_px + 16 && y >= m_py && y < m_py + 16) begin
            row = y - m_py;
            col = x - m_px;
            op  = (rom_mem[row][15 - col] == 1'b0);
        end
        if (m_press != 0) v = 8'h80;
        else if (hov)     v = 8'h00;
        else              v = 8'hFF;
        e.due = cyc + 2;
        e.exp = op ? {1'b1, v, v, v} : 25'd0;
        e.x   = x;
        e.y   = y;
        sb.push_back(e);
        if (fs) begin
            m_px = (int'(ArrowPosX) > 784) ? 784 : int'(ArrowPosX);
            m_py = (int'(ArrowPosY) > 584) ? 584 : int'(ArrowPosY);
        end
        if (clk_p)                     m_press = 8;
        else if (fs && m_press > 0)    m_press = m_press - 1;
    endtask

    task automatic idle(input logic fs, input logic clk_p);
        drive(0, 1023, 1'b0, fs, clk_p);
    endtask

    task automatic scan_row(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) drive(x, y, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({RqFlag3, Red3, Green3, Blue3} !== 25'd0) begin
            errors++;
            $display("FAIL reset_hold got %b_%h expected 0", RqFlag3, {Red3, Green3, Blue3});
        end
        reset = 1'b0;
        drive(384, 284, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        checks++;
        if ({RqFlag3, Red3, Green3, Blue3} !== 25'd0) begin
            errors++;
            $display("FAIL reset_release_latency got %b_%h expected 0", RqFlag3, {Red3, Green3, Blue3});
        end
        idle(1'b0, 1'b0);
        @(posedge clk); #2;
        checks++;
        if (RqFlag3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_home_hit got %b expected 1", RqFlag3);
        end
        // Asynchronous reset in the middle of a lit pixel
        reset = 1'b1;
        #1;
        checks++;
        if ({RqFlag3, Red3, Green3, Blue3} !== 25'd0) begin
            errors++;
            $display("FAIL reset_async got %b_%h expected 0", RqFlag3, {Red3, Green3, Blue3});
        end
        sb.delete();
        m_px = 384; m_py = 284; m_press = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(384, 284, 1'b0, 1'b0, 1'b0);
        drive(385, 285, 1'b0, 1'b0, 1'b0);
        drive(383, 284, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
    endtask

    task automatic test_basic_draw();
        ArrowPosX = 10'd100;
        ArrowPosY = 10'd50;
        idle(1'b1, 1'b0);
        scan_row(50, 99, 116);
        scan_row(53, 99, 116);
        idle(1'b0, 1'b0);
    endtask

    task automatic test_clamp_defer();
        ArrowPosX = 10'd790;
        ArrowPosY = 10'd595;
        scan_row(50, 99, 101);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        scan_row(584, 783, 800);
        scan_row(595, 790, 800);
        idle(1'b0, 1'b0);
    endtask

    task automatic test_hover();
        ArrowPosX = 10'd100;
        ArrowPosY = 10'd50;
        idle(1'b1, 1'b0);
        drive(100, 50, 1'b1, 1'b0, 1'b0);
        drive(101, 50, 1'b1, 1'b0, 1'b0);
        drive(100, 50, 1'b0, 1'b0, 1'b0);
        drive(102, 52, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
    endtask

    task automatic test_press();
        idle(1'b0, 1'b1);
        drive(100, 50, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        drive(100, 50, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            drive(100, 50, 1'b0, 1'b0, 1'b0);
            drive(101, 51, 1'b1, 1'b0, 1'b0);
            idle(1'b1, 1'b0);
        end
        drive(100, 50, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        ArrowPosX = 10'd0;
        ArrowPosY = 10'd50;
        idle(1'b1, 1'b0);
        drive(1023, 50, 1'b0, 1'b0, 1'b0);
        drive(0, 50, 1'b0, 1'b0, 1'b0);
        ArrowPosX = 10'd784;
        ArrowPosY = 10'd100;
        idle(1'b1, 1'b0);
        drive(799, 115, 1'b0, 1'b0, 1'b0);
        drive(800, 115, 1'b0, 1'b0, 1'b0);
        drive(799, 100, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        ArrowPosX = 10'd200;
        ArrowPosY = 10'd300;
        idle(1'b1, 1'b0);
        for (int i = 0; i < 120; i++) begin
            drive(198 + int'($urandom_range(0, 19)), 298 + int'($urandom_range(0, 19)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        idle(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            drive(200 + int'($urandom_range(0, 15)), 300 + int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        idle(1'b0, 1'b0);
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rom_mem[r] = ~(16'h8000 >> r);
        reset       = 1'b1;
        frame_start = 1'b0;
        click       = 1'b0;
        en_hover    = 1'b0;
        ArrowPosX   = 10'd0;
        ArrowPosY   = 10'd0;
        x_pos       = 10'd0;
        y_pos       = 10'd1023;

        test_reset();
        test_basic_draw();
        test_clamp_defer();
        test_hover();
        test_press();
        test_wrap();
        test_back_to_back();

        repeat (3) idle(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
